// File: rtl/memory_unit_pkg.sv
// Shared encodings and helpers for the memory unit and its RAM core.
// Holds DL/state encodings, the read-direction constant and lane helpers.
package memory_defs;

    typedef enum logic [1:0] {
        DL_BYTE   = 2'b00,
        DL_HALF   = 2'b01,
        DL_WORD   = 2'b10,
        DL_DOUBLE = 2'b11
    } dl_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BUSY  = 2'b01,
        S_BEAT2 = 2'b10,
        S_HOLD  = 2'b11
    } state_e;

    localparam logic RW_READ = 1'b1;

    // Byte-lane enables; lane 3 is the byte at the base address.
    function automatic logic [3:0] lane_en(input dl_e dl);
        logic [3:0] en;
        unique case (dl)
            DL_BYTE: en = 4'b1000;
            DL_HALF: en = 4'b1100;
            default: en = 4'b1111;
        endcase
        return en;
    endfunction

    // Move MDR low bits up so the first byte lands on the base address.
    function automatic logic [31:0] align_wr(input dl_e dl, input logic [31:0] d);
        logic [31:0] w;
        unique case (dl)
            DL_BYTE: w = {d[7:0], 24'h0};
            DL_HALF: w = {d[15:0], 16'h0};
            default: w = d;
        endcase
        return w;
    endfunction

    // Bring the leading bytes down to bit 0 and extend them.
    function automatic logic [31:0] extend_rd(input dl_e dl, input logic sig,
                                              input logic [31:0] r);
        logic [31:0] v;
        logic        fill;
        fill = sig & r[31];
        unique case (dl)
            DL_BYTE: v = {{24{fill}}, r[31:24]};
            DL_HALF: v = {{16{fill}}, r[31:16]};
            default: v = r;
        endcase
        return v;
    endfunction

    function automatic logic is_misaligned(input dl_e dl, input logic [1:0] a);
        logic m;
        unique case (dl)
            DL_BYTE: m = 1'b0;
            DL_HALF: m = a[0];
            default: m = |a;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/memory_unit_ram_core.sv
// Byte-array RAM with four big-endian byte lanes and wrapping addresses.
// Ports: clk_i, addr_i (base byte), we_i (lane 3 = base byte), wdata_i, rdata_o.
module ram_core #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            we_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0] mem_q [DEPTH];

    // Byte k of the 4-byte window sits at addr_i+k (mod depth) and in
    // data bits [31-8k -: 8].
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[3-k]) begin
                mem_q[addr_i + ADDR_WIDTH'(k)] <= wdata_i[31-8*k -: 8];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < 4; k++) begin
            rdata_o[31-8*k -: 8] = mem_q[addr_i + ADDR_WIDTH'(k)];
        end
    end

endmodule

// File: rtl/memory_unit.sv
// Fixed-latency big-endian RAM front end for the MAR/MDR path.
// Ports: clk, reset, MOV, RW, DL, SIG, address, data_in -> data_out, MOC
// (+ misaligned when MEM_ALIGN_CHECK_EN is defined).
module memory_unit
    import memory_defs::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MOV,
    input  logic                  RW,
    input  logic [1:0]            DL,
    input  logic                  SIG,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  MOC
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  misaligned
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  beat_q, beat_d;
    logic                  rw_q, sig_q;
    dl_e                   dl_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  moc_q, moc_d;
    logic [31:0]           dout_q, dout_d;

    logic                  active;
    logic                  commit;
    logic                  mis_now;
    dl_e                   beat_dl;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [3:0]            ram_we;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q, mis_d;
    assign mis_now    = is_misaligned(dl_e'(DL), address[1:0]);
    assign misaligned = mis_q;
`else
    assign mis_now    = 1'b0;
`endif

    assign active   = (state_q == S_BUSY) || (state_q == S_BEAT2);
    assign commit   = active && MOV && (cnt_q == 4'd0);
    // Each doubleword beat is a plain word access.
    assign beat_dl  = (dl_q == DL_DOUBLE) ? DL_WORD : dl_q;
    assign ram_addr = beat_q ? addr_q + ADDR_WIDTH'(4) : addr_q;

    ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // State register and access latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= 1'b0;
            rw_q    <= 1'b0;
            sig_q   <= 1'b0;
            dl_q    <= DL_BYTE;
            addr_q  <= '0;
            moc_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            moc_q   <= moc_d;
            dout_q  <= dout_d;
            if (state_q == S_IDLE && MOV) begin
                rw_q   <= RW;
                sig_q  <= SIG;
                dl_q   <= dl_e'(DL);
                addr_q <= address;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE: begin
                beat_d = 1'b0;
                if (MOV) begin
                    state_d = mis_now ? S_HOLD : S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY, S_BEAT2: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    beat_d  = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    if (state_q == S_BUSY && dl_q == DL_DOUBLE) begin
                        state_d = S_BEAT2;
                        cnt_d   = CNT_LOAD;
                        beat_d  = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    beat_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        moc_d     = moc_q;
        dout_d    = dout_q;
        ram_we    = 4'b0000;
        ram_wdata = align_wr(beat_dl, data_in);
`ifdef MEM_ALIGN_CHECK_EN
        mis_d     = mis_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                moc_d = MOV && mis_now;
`ifdef MEM_ALIGN_CHECK_EN
                mis_d = MOV && mis_now;
`endif
            end
            S_BUSY, S_BEAT2: begin
                // MOC is a one-cycle pulse between doubleword beats.
                moc_d = commit;
                if (commit && rw_q == RW_READ) begin
                    dout_d = extend_rd(beat_dl, sig_q, ram_rdata);
                end
                if (commit && rw_q != RW_READ && !reset) begin
                    ram_we = lane_en(beat_dl);
                end
            end
            S_HOLD: begin
                moc_d = MOV;
`ifdef MEM_ALIGN_CHECK_EN
                if (!MOV) mis_d = 1'b0;
`endif
            end
            default: moc_d = 1'b0;
        endcase
    end

    assign MOC      = moc_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit against a byte-array reference model.
module tb_memory_unit;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        MOV;
    logic        RW;
    logic [1:0]  DL;
    logic        SIG;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        MOC;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  m [256];
    logic [31:0] exp_dout;

    memory_unit #(
        .ADDR_WIDTH (8),
        .LATENCY    (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MOV      (MOV),
        .RW       (RW),
        .DL       (DL),
        .SIG      (SIG),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .MOC      (MOC)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misaligned (misaligned)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [7:0] a,
                                               input logic [1:0] dl,
                                               input logic sig);
        logic [31:0] v;
        logic [7:0]  a1, a2, a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        if (dl == 2'b00) begin
            v = {24'h0, m[a]};
            if (sig && m[a][7]) v = v | 32'hFFFF_FF00;
        end else if (dl == 2'b01) begin
            v = {16'h0, m[a], m[a1]};
            if (sig && m[a][7]) v = v | 32'hFFFF_0000;
        end else begin
            v = {m[a], m[a1], m[a2], m[a3]};
        end
        return v;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [1:0] dl,
                               input logic [31:0] d);
        if (dl == 2'b00) begin
            m[a] = d[7:0];
        end else if (dl == 2'b01) begin
            m[a] = d[15:8];
            m[a + 8'd1] = d[7:0];
        end else begin
            m[a] = d[31:24];
            m[a + 8'd1] = d[23:16];
            m[a + 8'd2] = d[15:8];
            m[a + 8'd3] = d[7:0];
        end
    endtask

    // One full handshake; called just after a rising edge with state IDLE.
    task automatic access(input logic rw, input logic [1:0] dl,
                          input logic sig, input logic [7:0] a,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input string tag);
        int          nb;
        logic [7:0]  ba;
        logic [1:0]  bdl;
        nb  = (dl == 2'b11) ? 2 : 1;
        bdl = (dl == 2'b11) ? 2'b10 : dl;
        MOV = 1'b1; RW = rw; DL = dl; SIG = sig;
        address = a; data_in = d1;
        @(posedge clk); #1;
        // Everything but MOV/data_in is don't-care after the latch edge.
        RW = ~rw; DL = ~dl; SIG = ~sig; address = ~a;
        for (int b = 0; b < nb; b++) begin
            ba = a + 8'(4 * b);
            if (b == 1) data_in = d2;
            for (int n = 1; n <= LAT; n++) begin
                @(posedge clk); #1;
                if (n == LAT) begin
                    if (rw) exp_dout = model_read(ba, bdl, sig);
                    else    model_write(ba, bdl, (b == 1) ? d2 : d1);
                end
                n_cmp++;
                if (MOC !== (n == LAT)) begin
                    n_bad++;
                    $display("FAIL %s moc beat%0d cyc%0d: got %b want %b",
                             tag, b, n, MOC, (n == LAT));
                end
                n_cmp++;
                if (data_out !== exp_dout) begin
                    n_bad++;
                    $display("FAIL %s dout beat%0d cyc%0d: got %h want %h",
                             tag, b, n, data_out, exp_dout);
                end
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (MOC !== 1'b1) begin
            n_bad++;
            $display("FAIL %s moc_hold: got %b want 1", tag, MOC);
        end
        MOV = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (MOC !== 1'b0 || data_out !== exp_dout) begin
            n_bad++;
            $display("FAIL %s release: moc %b dout %h want 0 %h",
                     tag, MOC, data_out, exp_dout);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; MOV = 1'b0; RW = 1'b0; DL = 2'b00; SIG = 1'b0;
        address = '0; data_in = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_dout = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (MOC !== 1'b0 || data_out !== 32'h0) begin
                n_bad++;
                $display("FAIL reset cyc%0d: moc %b dout %h want 0 0",
                         i, MOC, data_out);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 64; i++) begin
            access(1'b0, 2'b10, 1'b0, 8'(4 * i), $urandom, 32'h0, "fill");
        end
    endtask

    task automatic test_word_rw();
        access(1'b0, 2'b10, 1'b0, 8'h10, 32'hE200_1028, 32'h0, "wr_word");
        access(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, 32'h0, "rd_word");
        n_cmp++;
        if (data_out !== 32'hE200_1028) begin
            n_bad++;
            $display("FAIL rd_word_const: got %h want e2001028", data_out);
        end
        access(1'b1, 2'b00, 1'b0, 8'h10, 32'h0, 32'h0, "rd_byte");
        n_cmp++;
        if (data_out !== 32'h0000_00E2) begin
            n_bad++;
            $display("FAIL rd_byte_const: got %h want 000000e2", data_out);
        end
    endtask

    task automatic test_sign_ext();
        access(1'b1, 2'b00, 1'b1, 8'h13, 32'h0, 32'h0, "sx_pos");
        n_cmp++;
        if (data_out !== 32'h0000_0028) begin
            n_bad++;
            $display("FAIL sx_pos_const: got %h want 00000028", data_out);
        end
        access(1'b0, 2'b00, 1'b0, 8'h20, 32'h1234_5685, 32'h0, "wr_b85");
        access(1'b1, 2'b00, 1'b1, 8'h20, 32'h0, 32'h0, "sx_neg");
        n_cmp++;
        if (data_out !== 32'hFFFF_FF85) begin
            n_bad++;
            $display("FAIL sx_neg_const: got %h want ffffff85", data_out);
        end
        access(1'b1, 2'b00, 1'b0, 8'h20, 32'h0, 32'h0, "zx_b85");
        n_cmp++;
        if (data_out !== 32'h0000_0085) begin
            n_bad++;
            $display("FAIL zx_const: got %h want 00000085", data_out);
        end
        access(1'b0, 2'b01, 1'b0, 8'h31, 32'h0000_9A0B, 32'h0, "wr_half");
        access(1'b1, 2'b01, 1'b1, 8'h31, 32'h0, 32'h0, "sx_half");
        n_cmp++;
        if (data_out !== 32'hFFFF_9A0B) begin
            n_bad++;
            $display("FAIL sx_half_const: got %h want ffff9a0b", data_out);
        end
    endtask

    task automatic test_double();
        access(1'b0, 2'b11, 1'b0, 8'hFC, 32'h1122_3344, 32'hAABB_CCDD, "wr_dbl");
        access(1'b1, 2'b10, 1'b0, 8'hFC, 32'h0, 32'h0, "rd_fc");
        n_cmp++;
        if (data_out !== 32'h1122_3344) begin
            n_bad++;
            $display("FAIL rd_fc_const: got %h want 11223344", data_out);
        end
        access(1'b1, 2'b10, 1'b0, 8'h00, 32'h0, 32'h0, "rd_00");
        n_cmp++;
        if (data_out !== 32'hAABB_CCDD) begin
            n_bad++;
            $display("FAIL rd_00_const: got %h want aabbccdd", data_out);
        end
        access(1'b1, 2'b11, 1'b0, 8'hFC, 32'h0, 32'h0, "rd_dbl");
    endtask

    task automatic test_abort();
        MOV = 1'b1; RW = 1'b0; DL = 2'b10; SIG = 1'b0;
        address = 8'h40; data_in = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        MOV = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (MOC !== 1'b0 || data_out !== exp_dout) begin
                n_bad++;
                $display("FAIL abort cyc%0d: moc %b dout %h want 0 %h",
                         i, MOC, data_out, exp_dout);
            end
        end
        access(1'b1, 2'b10, 1'b0, 8'h40, 32'h0, 32'h0, "abort_rd");
    endtask

    task automatic test_reset_busy();
        MOV = 1'b1; RW = 1'b0; DL = 2'b10; SIG = 1'b0;
        address = 8'h44; data_in = 32'hCAFE_F00D;
        @(posedge clk); #1;
        reset = 1'b1;
        MOV = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_dout = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (MOC !== 1'b0 || data_out !== 32'h0) begin
                n_bad++;
                $display("FAIL rst_busy cyc%0d: moc %b dout %h want 0 0",
                         i, MOC, data_out);
            end
        end
        access(1'b1, 2'b10, 1'b0, 8'h44, 32'h0, 32'h0, "rst_busy_rd");
    endtask

    task automatic test_random();
        logic       rw;
        logic [1:0] dl;
        logic [7:0] a;
        for (int i = 0; i < 80; i++) begin
            rw = 1'($urandom);
            dl = 2'($urandom);
            a  = 8'($urandom);
`ifdef MEM_ALIGN_CHECK_EN
            if (dl == 2'b01) a[0] = 1'b0;
            if (dl[1])       a[1:0] = 2'b00;
`endif
            access(rw, dl, 1'($urandom), a, $urandom, $urandom, "random");
        end
    endtask

    task automatic test_back_to_back();
        access(1'b0, 2'b11, 1'b0, 8'h80, 32'h0102_0304, 32'h0506_0708, "b2b_w");
        access(1'b1, 2'b11, 1'b1, 8'h80, 32'h0, 32'h0, "b2b_r");
        n_cmp++;
        if (data_out !== 32'h0506_0708) begin
            n_bad++;
            $display("FAIL b2b_const: got %h want 05060708", data_out);
        end
        access(1'b1, 2'b01, 1'b1, 8'h82, 32'h0, 32'h0, "b2b_h");
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic test_misaligned();
        MOV = 1'b1; RW = 1'b1; DL = 2'b01; SIG = 1'b0;
        address = 8'h11; data_in = '0;
        @(posedge clk); #1;
        n_cmp++;
        if (MOC !== 1'b1 || misaligned !== 1'b1 || data_out !== exp_dout) begin
            n_bad++;
            $display("FAIL misalign_set: moc %b mis %b dout %h want 1 1 %h",
                     MOC, misaligned, data_out, exp_dout);
        end
        @(posedge clk); #1;
        MOV = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (MOC !== 1'b0 || misaligned !== 1'b0 || data_out !== exp_dout) begin
            n_bad++;
            $display("FAIL misalign_clr: moc %b mis %b dout %h want 0 0 %h",
                     MOC, misaligned, data_out, exp_dout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_word_rw();
        test_sign_ext();
        test_double();
        test_abort();
        test_reset_busy();
        test_random();
        test_back_to_back();
`ifdef MEM_ALIGN_CHECK_EN
        test_misaligned();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
Name: memory_unit

Overview:
- Byte-addressable data/instruction RAM that sits directly downstream of the control unit and MAR/MDR.
- Consumes MOV, RW, DL and SIG from the control unit, plus the address from MAR and write data from MDR.
- Returns read data to MDR and raises MOC to release the control unit's wait states.
- Big-endian, fixed access latency, and doubleword transfers are issued as two word beats.

Parameters:
- ADDR_WIDTH, 8: byte address width; depth is 2^ADDR_WIDTH bytes.
- LATENCY, 2: cycles from MOV sampled high to MOC; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MOV  input  1  memory operation valid; held high by the control unit until MOC is seen.
- RW  input  1  1 = read, 0 = write.
- DL  input  2  data length: 00 byte, 01 halfword, 10 word, 11 doubleword.
- SIG  input  1  1 = sign-extend byte/halfword reads; 0 = zero-extend.
- address  input  ADDR_WIDTH  byte address from MAR.
- data_in  input  32  write data from MDR; low bits are used for byte/halfword.
- data_out  output  32  registered read data to MDR.
- MOC  output  1  memory operation complete.

Behaviour:
- Reset (synchronous, active-high): MOC=0, data_out=0, state=IDLE, beat=0. RAM contents are not cleared.
- States: IDLE, BUSY, BEAT2, HOLD.
- IDLE: when MOV=1 at an edge, latch RW, DL, SIG and address; load cnt=LATENCY-1; go to BUSY.
- BUSY: decrement cnt each edge. At the edge where cnt=0 the access commits:
  - Read: data_out is updated.
  - Write: bytes are written.
  - MOC goes to 1 on that same edge, so MOC rises LATENCY edges after MOV was sampled.
- Non-doubleword access: after commit go to HOLD.
- HOLD: MOC stays 1 while MOV=1. On the first edge with MOV=0, MOC goes to 0 and the state returns to IDLE. A new access can start on the following edge.
- Doubleword (DL=11):
  - Beat 1 is a word access at addr and commits as above. MOC is a single-cycle pulse.
  - Go to BEAT2 and reload cnt=LATENCY-1. Beat 2 is a word access at (addr+4) mod 2^ADDR_WIDTH.
  - MOC rises again LATENCY edges after beat 1 commits, then the state goes to HOLD.
  - For a write, data_in is sampled separately at each beat's commit edge.
- Byte order is big-endian: the byte at addr is bits [31:24] of a word.
  - Halfword occupies data[15:0]: addr maps to [15:8], addr+1 to [7:0].
  - Byte occupies data[7:0].
- Read extension: byte and halfword reads fill the upper bits with zeros when SIG=0, or with the top bit of the read data when SIG=1.
- Byte addresses within any multi-byte access wrap modulo 2^ADDR_WIDTH. No alignment is enforced unless the optional feature is enabled.
- MOV dropped before commit: abort, return to IDLE, no write, MOC stays 0, data_out unchanged.
- Reset mid-operation has priority. An uncommitted write is discarded; a committed beat-1 write of a doubleword is kept.
- Inputs other than MOV and data_in are ignored after the latch edge.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - Adds output `misaligned` (1 bit, reset 0).
  - An access is misaligned if a halfword has addr[0]≠0, or a word/doubleword has addr[1:0]≠0.
  - A misaligned access is detected at the latch edge. It performs no RAM read or write, leaves data_out unchanged, sets misaligned=1, and enters HOLD with MOC=1 so the control unit is not deadlocked.
  - misaligned clears when HOLD exits.
- MEM_ALIGN_CHECK_EN undefined: no port; unaligned accesses are performed byte-wise as specified above.

Decomposition:
- Package memory_defs holds:
  - DL encodings: DL_BYTE, DL_HALF, DL_WORD, DL_DOUBLE.
  - State encodings: S_IDLE, S_BUSY, S_BEAT2, S_HOLD.
  - Constant RW_READ = 1.
- Sub-module ram_core is the natural split:
  - Contents: byte array, 4 byte-lane write enables, 4-byte big-endian read at a base address with wrap.
  - memory_unit contains the FSM, latency counter, extension logic and beat handling.

Test Plan:
- Reset: with reset=1 for 1 edge, then MOV=0 → MOC=0, data_out=0 for 5 cycles.
- Word write then read, LATENCY=2:
  - Write addr=0x10, data_in=0xE2001028, MOV high at edge k → MOC=1 at k+2, held until MOV low, cleared next edge.
  - Read addr=0x10 → data_out=0xE2001028; byte read at 0x10 → 0x000000E2.
- Sign extension: byte read at 0x13 (contents 0x28 after the word write) with SIG=1 → 0x00000028. Byte write 0x85 at 0x20, then read with SIG=1 → 0xFFFFFF85; with SIG=0 → 0x00000085.
- Doubleword write:
  - DL=11 at addr=0xFC with data_in 0x11223344 for beat 1 and 0xAABBCCDD for beat 2.
  - MOC pulses at k+2, then rises again at k+4.
  - Word reads: 0xFC → 0x11223344, 0x00 (wrapped) → 0xAABBCCDD.
- Abort and reset:
  - Write word 0xDEADBEEF at 0x40 with MOV dropped at k+1 → no MOC; a later read of 0x40 returns the old value.
  - Reset asserted during BUSY → MOC stays 0 and state returns to IDLE.
- MEM_ALIGN_CHECK_EN: halfword read at 0x11 → misaligned=1 and MOC=1 from the latch edge, data_out unchanged, both cleared after MOV drops.
